mbist_march_ctrl: RTL and testbench
===================================

# mbist_march_ctrl

Built-in self-test controller that drives the single-port test memory (`fault_mem`) through a March C- algorithm and checks every read. It is the initiator on the memory's `write_read`/`address`/`wdata`/`rdata` interface. It issues one operation per cycle, pipelines the expected data against the memory's two-cycle read latency, and reports pass/fail with the first failing address, element and data.

## Interface
- `DATA_WIDTH`, default 8: memory word width.
- `ADDR_WIDTH`, default 4: address width; test covers N = 2**ADDR_WIDTH words, 0..N-1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: begin a test; sampled only in IDLE or DONE.
- `busy` out 1: high in RUN; reset 0.
- `done` out 1: high in DONE; reset 0.
- `fail` out 1: valid with `done`; reset 0.
- `fail_addr` out ADDR_WIDTH: address of the first mismatching read; reset 0.
- `fail_element` out 3: March element (0..5) of the first mismatch; reset 0.
- `fail_data` out DATA_WIDTH: `rdata` captured at the first mismatch; reset 0.
- `write_read` out 1: 1 = write, 0 = read; reset 0.
- `address` out ADDR_WIDTH: memory address; reset 0.
- `wdata` out DATA_WIDTH: write data, one cycle ahead (see Timing); reset 0.
- `rdata` in DATA_WIDTH: memory read data.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE to RUN when `start` is sampled.
  - RUN to DONE after the last compare, or at the first mismatch.
  - DONE to RUN when `start` is sampled; this clears `fail` and all `fail_*`.
  - `start` in RUN is ignored.
- March C- elements, with background 0 = all zeros and 1 = all ones:
  - 0: ⇑ w0
  - 1: ⇑ r0,w1
  - 2: ⇑ r1,w0
  - 3: ⇓ r0,w1
  - 4: ⇓ r1,w0
  - 5: ⇑ r0
- Total ops = 10N. ⇑ runs 0 to N-1; ⇓ runs N-1 to 0.
- In two-op elements, the read and the write to one address occupy consecutive cycles, then the address advances.
- Each read pushes {expected, address, element} into a 3-deep shift pipeline. The compare happens when the entry exits.
- First mismatch: latch `fail`=1, `fail_addr`, `fail_element` and `fail_data`=`rdata`, then go to DONE immediately. Reads still in flight are discarded.
- Outside RUN: `write_read`=0, `address`=0, `wdata`=0. The memory sees harmless reads.
- Asserting `rst_n` low at any time, including mid-test, returns to IDLE with all outputs at their reset values. No partial result is kept.

## Timing
- E0 is the edge at which `start` is sampled. Op i (i = 0..10N-1) drives `write_read` and `address` in the cycle after edge E_i.
- `wdata` in the cycle of op i equals the write data of op i+1. This compensates for the memory's internal `wdata` register, which delays write data by one cycle.
  - In IDLE/DONE, `wdata`=0, which is the data of op 0.
  - When op i+1 is a read, `wdata` is don't-care but is driven to the current background.
- A read issued in cycle after E_i appears on `rdata` in the cycle after E_{i+2}. The compare result is registered at E_{i+3}.
- Clean pass: `busy` falls and `done` rises at E_{10N+2}. For ADDR_WIDTH=4 this is E162.
- Fail: `done` and `fail` rise at the edge E_{i+3} following the failing read i.
- `address` counts with ADDR_WIDTH-bit arithmetic. Wrap at N-1 to 0 (⇑) or 0 to N-1 (⇓) is the element-end condition, never a memory access.

## Structure
- Package `mbist_pkg`:
  - state enum {IDLE, RUN, DONE}
  - element enum (3 bits, values 0..5)
  - per-element constants: direction, read polarity, write polarity, ops-per-address.
- Sub-module `mbist_march_seq`: generates the op stream (element, address, phase, next-op write data) from an `advance` input and flags `last_op`.
- The top level holds the FSM, the 3-deep expect pipeline, the comparator and the result registers.

## Test plan
- Fault-free memory model, ADDR_WIDTH=4, DATA_WIDTH=8, pulse `start` → `done`=1 at E162, `fail`=0, 80 writes and 80 reads observed, `busy` high E0 to E162.
- Memory with bit0 of address 5 stuck-at-1 → `fail`=1, `fail_addr`=5, `fail_element`=1, `fail_data`=8'h01.
- `fault_mem` built with a coupling fault at address 9 (a write of 0 to address 9 flips bit1 of address 10) → `fail`=1, `fail_addr`=10, `fail_element`=2, `fail_data`=8'hFD.
- Check the write-data offset: for every write op at edge E_i, the monitor shows `wdata` in cycle E_{i-1} equal to the background (8'h00 or 8'hFF).
- Drop `rst_n` at E40 mid-run → all outputs 0, state IDLE. A fresh `start` completes a clean pass in 162 cycles.
- `start` held high throughout RUN has no effect. A `start` in DONE after a fail clears `fail` and `fail_*` at E0 and re-runs.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and per-element March C- properties for the MBIST controller.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        EL_UP_W0   = 3'd0,
        EL_UP_R0W1 = 3'd1,
        EL_UP_R1W0 = 3'd2,
        EL_DN_R0W1 = 3'd3,
        EL_DN_R1W0 = 3'd4,
        EL_UP_R0   = 3'd5
    } elem_e;

    function automatic logic elem_down(elem_e e);
        return (e == EL_DN_R0W1) || (e == EL_DN_R1W0);
    endfunction

    function automatic logic elem_rpol(elem_e e);
        return (e == EL_UP_R1W0) || (e == EL_DN_R1W0);
    endfunction

    function automatic logic elem_wpol(elem_e e);
        return (e == EL_UP_R0W1) || (e == EL_DN_R0W1);
    endfunction

    // Two ops per address (read then write); otherwise a single op.
    function automatic logic elem_two_op(elem_e e);
        return (e != EL_UP_W0) && (e != EL_UP_R0);
    endfunction

endpackage

// File: rtl/mbist_march_seq.sv
// March C- op-stream generator: current op plus the write data of the op after it.
module mbist_march_seq
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic                  advance,
    output elem_e                 op_elem,
    output logic [ADDR_WIDTH-1:0] op_addr,
    output logic                  op_write,
    output logic [DATA_WIDTH-1:0] op_exp,
    output logic [DATA_WIDTH-1:0] next_wdata,
    output logic                  last_op
);

    elem_e                 elem_q, elem_d, nxt_elem;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, nxt_addr;
    logic                  phase_q, phase_d, nxt_phase;
    logic                  wrap, nxt_write;

    always_comb begin
        nxt_elem  = elem_q;
        nxt_addr  = addr_q;
        nxt_phase = 1'b0;
        wrap      = elem_down(elem_q) ? (addr_q == '0) : (addr_q == '1);
        if (elem_two_op(elem_q) && !phase_q) begin
            nxt_phase = 1'b1;
        end else if (wrap) begin
            // Address wrap ends the element; the last element wraps back to op 0.
            nxt_elem = (elem_q == EL_UP_R0) ? EL_UP_W0 : elem_e'(elem_q + 3'd1);
            nxt_addr = elem_down(nxt_elem) ? '1 : '0;
        end else begin
            nxt_addr = elem_down(elem_q) ? addr_q - 1'b1 : addr_q + 1'b1;
        end
        nxt_write  = elem_two_op(nxt_elem) ? nxt_phase : (nxt_elem == EL_UP_W0);
        next_wdata = {DATA_WIDTH{nxt_write ? elem_wpol(nxt_elem) : elem_rpol(nxt_elem)}};

        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        if (restart) begin
            elem_d  = EL_UP_W0;
            addr_d  = '0;
            phase_d = 1'b0;
        end else if (advance) begin
            elem_d  = nxt_elem;
            addr_d  = nxt_addr;
            phase_d = nxt_phase;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_q  <= EL_UP_W0;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
        end
    end

    assign op_elem  = elem_q;
    assign op_addr  = addr_q;
    assign op_write = elem_two_op(elem_q) ? phase_q : (elem_q == EL_UP_W0);
    assign op_exp   = {DATA_WIDTH{elem_rpol(elem_q)}};
    assign last_op  = (elem_q == EL_UP_R0) && (addr_q == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: FSM, 3-deep expected-data pipeline, comparator, result registers.
// state   | meaning
// IDLE    | waiting for start, bus parked on harmless reads
// RUN     | issuing ops and comparing read data
// DONE    | result valid on fail/fail_*; start re-runs
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata
);

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DATA_WIDTH-1:0] exp_data;
        logic [ADDR_WIDTH-1:0] addr;
        elem_e                 elem;
    } pipe_t;

    state_e                state_q, state_d;
    logic                  issued_all_q, issued_all_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    elem_e                 fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic                  write_read_q, write_read_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    pipe_t                 pipe_q [3];
    pipe_t                 pipe_d [3];

    logic                  issue, mismatch, seq_restart;
    elem_e                 seq_elem;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic                  seq_write, seq_last;
    logic [DATA_WIDTH-1:0] seq_exp, seq_next_wdata;

    mbist_march_seq #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (seq_restart),
        .advance   (issue),
        .op_elem   (seq_elem),
        .op_addr   (seq_addr),
        .op_write  (seq_write),
        .op_exp    (seq_exp),
        .next_wdata(seq_next_wdata),
        .last_op   (seq_last)
    );

    assign mismatch = pipe_q[2].valid && (rdata != pipe_q[2].exp_data);

    always_comb begin
        state_d      = state_q;
        issued_all_d = issued_all_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_data_d  = fail_data_q;
        issue        = 1'b0;
        seq_restart  = 1'b0;
        pipe_d[0]    = '0;
        pipe_d[1]    = pipe_q[0];
        pipe_d[2]    = pipe_q[1];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    issue        = 1'b1;
                    issued_all_d = 1'b0;
                    fail_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_elem_d  = EL_UP_W0;
                    fail_data_d  = '0;
                end else begin
                    seq_restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (mismatch) begin
                    // Reads still in flight are dropped with the pipeline.
                    state_d     = ST_DONE;
                    seq_restart = 1'b1;
                    fail_d      = 1'b1;
                    fail_addr_d = pipe_q[2].addr;
                    fail_elem_d = pipe_q[2].elem;
                    fail_data_d = rdata;
                    pipe_d[1]   = '0;
                    pipe_d[2]   = '0;
                end else if (pipe_q[2].valid && pipe_q[2].last) begin
                    state_d     = ST_DONE;
                    seq_restart = 1'b1;
                end else if (!issued_all_q) begin
                    issue = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        write_read_d = 1'b0;
        address_d    = '0;
        wdata_d      = '0;
        if (issue) begin
            write_read_d = seq_write;
            address_d    = seq_addr;
            wdata_d      = seq_next_wdata;
            if (seq_last) issued_all_d = 1'b1;
            if (!seq_write) pipe_d[0] = '{valid: 1'b1, last: seq_last, exp_data: seq_exp,
                                          addr: seq_addr, elem: seq_elem};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issued_all_q <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= EL_UP_W0;
            fail_data_q  <= '0;
            write_read_q <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            pipe_q[0]    <= '0;
            pipe_q[1]    <= '0;
            pipe_q[2]    <= '0;
        end else begin
            state_q      <= state_d;
            issued_all_q <= issued_all_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_data_q  <= fail_data_d;
            write_read_q <= write_read_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            pipe_q[0]    <= pipe_d[0];
            pipe_q[1]    <= pipe_d[1];
            pipe_q[2]    <= pipe_d[2];
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign fail         = fail_q;
    assign fail_addr    = fail_addr_q;
    assign fail_element = fail_elem_q;
    assign fail_data    = fail_data_q;
    assign write_read   = write_read_q;
    assign address      = address_q;
    assign wdata        = wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: cycle model of fault_mem plus an op-list reference of March C-.
module tb_mbist_march_ctrl;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int N    = 16;
    localparam int NOPS = 10 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, write_read;
    logic [AW-1:0] fail_addr, address;
    logic [2:0]    fail_element;
    logic [DW-1:0] fail_data, wdata;
    logic [DW-1:0] rdata = '0;

    mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .fail_addr   (fail_addr),
        .fail_element(fail_element),
        .fail_data   (fail_data),
        .write_read  (write_read),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 fault-free, 1 stuck-at-1 bit0 @5, 2 coupling 9 -> 10 bit1

    // fault_mem: write data registered one cycle, two-cycle read latency.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] wdata_r = '0;
    logic [DW-1:0] rd1 = '0;
    always @(posedge clk) begin
        if (write_read) begin
            mem[address] <= wdata_r;
            if (mode == 2 && address == 4'd9 && wdata_r == 8'h00) mem[10] <= mem[10] ^ 8'h02;
        end
        wdata_r <= wdata;
        rd1     <= mem[address] | ((mode == 1 && address == 4'd5) ? 8'h01 : 8'h00);
        rdata   <= rd1;
    end

    // Reference op list built from the March C- description.
    int            op_we   [NOPS];
    int            op_addr [NOPS];
    int            op_elem [NOPS];
    logic [DW-1:0] op_data [NOPS];

    int            exp_fail_i, exp_end, exp_faddr, exp_felem;
    logic [DW-1:0] exp_fdata;
    int            wr_cnt, rd_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_ops();
        int el_down [6] = '{0, 0, 0, 1, 1, 0};
        int el_rd   [6] = '{-1, 0, 1, 0, 1, 0};
        int el_wr   [6] = '{0, 1, 0, 1, 0, -1};
        int n = 0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                int a = el_down[e] ? N - 1 - j : j;
                if (el_rd[e] >= 0) begin
                    op_we[n] = 0; op_addr[n] = a; op_elem[n] = e;
                    op_data[n] = el_rd[e] ? 8'hFF : 8'h00; n++;
                end
                if (el_wr[e] >= 0) begin
                    op_we[n] = 1; op_addr[n] = a; op_elem[n] = e;
                    op_data[n] = el_wr[e] ? 8'hFF : 8'h00; n++;
                end
            end
        end
    endtask

    task automatic predict(input int m);
        logic [DW-1:0] mm [N];
        logic [DW-1:0] v;
        exp_fail_i = -1;
        exp_faddr = 0; exp_felem = 0; exp_fdata = '0;
        for (int a = 0; a < N; a++) mm[a] = '0;
        for (int i = 0; i < NOPS && exp_fail_i < 0; i++) begin
            if (op_we[i] != 0) begin
                if (m == 2 && op_addr[i] == 9 && op_data[i] == 8'h00) mm[10] ^= 8'h02;
                mm[op_addr[i]] = op_data[i];
            end else begin
                v = mm[op_addr[i]];
                if (m == 1 && op_addr[i] == 5) v |= 8'h01;
                if (v != op_data[i]) begin
                    exp_fail_i = i; exp_faddr = op_addr[i];
                    exp_felem = op_elem[i]; exp_fdata = v;
                end
            end
        end
        exp_end = (exp_fail_i < 0) ? NOPS + 2 : exp_fail_i + 3;
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, busy, done, fail, fail_addr, fail_element, fail_data, write_read, address, wdata};
    endfunction

    // Pulse (or hold) start, then check every cycle from E0 up to the predicted end edge.
    task automatic run_test(input int m, input bit hold, input int abort_at, output int obs_end);
        mode = m;
        predict(m);
        wr_cnt = 0; rd_cnt = 0; obs_end = -1;
        @(negedge clk);
        chk("wdata_idle_op0", wdata, 0);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= exp_end; k++) begin
            @(negedge clk);
            if (!hold || k == exp_end) start = 1'b0;
            if (k == abort_at) begin
                rst_n = 1'b0; start = 1'b0;
                #1;
                chk("reset_outputs", all_outs(), 0);
                repeat (2) @(negedge clk);
                chk("reset_held_idle", all_outs(), 0);
                return;
            end
            if (done && obs_end < 0) obs_end = k;
            if (k < exp_end) begin
                chk("busy_run", busy, 1);
                chk("done_run", done, 0);
                chk("result_cleared", {fail, fail_addr, fail_element, fail_data}, 0);
                if (k < NOPS) begin
                    chk("write_read", write_read, op_we[k]);
                    chk("address", address, op_addr[k]);
                    if (k + 1 < NOPS && op_we[k+1] != 0) chk("wdata_ahead", wdata, op_data[k+1]);
                    if (write_read) wr_cnt++; else rd_cnt++;
                end
            end else begin
                chk("busy_end", busy, 0);
                chk("done_end", done, 1);
                chk("fail_end", fail, (exp_fail_i >= 0) ? 1 : 0);
                chk("fail_addr_end", fail_addr, exp_faddr);
                chk("fail_elem_end", fail_element, exp_felem);
                chk("fail_data_end", fail_data, exp_fdata);
                chk("bus_parked", {write_read, address, wdata}, 0);
            end
        end
    endtask

    int e;

    initial begin
        build_ops();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", all_outs(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", all_outs(), 0);

        run_test(0, 1'b0, -1, e);
        chk("clean_done_edge", e, 162);
        chk("clean_writes", wr_cnt, 80);
        chk("clean_reads", rd_cnt, 80);
        chk("clean_fail", fail, 0);

        run_test(1, 1'b0, -1, e);
        chk("stuck_done_edge", e, 29);
        chk("stuck_fail", fail, 1);
        chk("stuck_addr", fail_addr, 5);
        chk("stuck_elem", fail_element, 1);
        chk("stuck_data", fail_data, 8'h01);

        repeat (3) @(negedge clk);
        chk("done_holds", {done, fail, fail_addr}, {1'b1, 1'b1, 4'd5});

        run_test(0, 1'b0, -1, e);
        chk("rerun_done_edge", e, 162);
        chk("rerun_fail", fail, 0);

        run_test(2, 1'b0, -1, e);
        chk("coupling_done_edge", e, 71);
        chk("coupling_fail", fail, 1);
        chk("coupling_addr", fail_addr, 10);
        chk("coupling_elem", fail_element, 2);
        chk("coupling_data", fail_data, 8'hFD);

        run_test(0, 1'b1, -1, e);
        chk("held_start_done_edge", e, 162);

        run_test(0, 1'b0, 40, e);
        @(negedge clk);
        rst_n = 1'b1;
        run_test(0, 1'b0, -1, e);
        chk("post_reset_done_edge", e, 162);
        chk("post_reset_fail", fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
